// File: rtl/spi_regfile.sv
// SPI-slave (mode 0) register file with readback on MISO and auto-incrementing burst access.
// SPI pins are synchronised into clk_i; all outputs are registered.
module spi_regfile #(
    parameter int unsigned NUM_REGISTERS = 8,
    parameter int unsigned LEN_REGISTER  = 8,
    parameter logic [NUM_REGISTERS*LEN_REGISTER-1:0] RESET_VALUES = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    input  logic                                  spi_sclk_i,
    input  logic                                  spi_mosi_i,
    input  logic                                  spi_cs_i,
    output logic                                  spi_miso_o,
    output logic [NUM_REGISTERS*LEN_REGISTER-1:0] regs_o,
    output logic                                  wr_strobe_o,
    output logic [6:0]                            wr_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA
    } state_t;

    state_t                                state_q;
    logic                                  sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                                  mosi_s1_q, mosi_s2_q;
    logic                                  cs_s1_q, cs_s2_q;
    logic [5:0]                            cnt_q;
    logic [6:0]                            cmd_q;
    logic [LEN_REGISTER-2:0]               data_q;
    logic [LEN_REGISTER-2:0]               shift_q;
    logic [6:0]                            addr_q;
    logic                                  rd_q;
    logic                                  load_q;
    logic                                  miso_q;
    logic [NUM_REGISTERS*LEN_REGISTER-1:0] regs_q;
    logic                                  strobe_q;
    logic [6:0]                            wr_addr_q;

    logic                    rise, fall, in_range, last_bit;
    logic [7:0]              cmd_d;
    logic [LEN_REGISTER-1:0] data_d;
    logic [LEN_REGISTER-1:0] rd_word_d;
    logic [6:0]              addr_d;

    always_comb begin
        rise      = sclk_s2_q & ~sclk_s3_q;
        fall      = ~sclk_s2_q & sclk_s3_q;
        cmd_d     = {cmd_q, mosi_s2_q};
        data_d    = {data_q, mosi_s2_q};
        in_range  = {25'd0, addr_q} < NUM_REGISTERS;
        last_bit  = cnt_q == 6'(LEN_REGISTER - 1);
        rd_word_d = '0;
        if (in_range) begin
            rd_word_d = regs_q[addr_q*LEN_REGISTER +: LEN_REGISTER];
        end
        // Out-of-range addresses also wrap, so a burst resumes at register 0.
        if ({25'd0, addr_q} >= NUM_REGISTERS - 1) begin
            addr_d = '0;
        end else begin
            addr_d = addr_q + 7'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            load_q    <= 1'b0;
            miso_q    <= 1'b0;
            regs_q    <= RESET_VALUES;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            sclk_s1_q <= spi_sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= spi_mosi_i;
            mosi_s2_q <= mosi_s1_q;
            cs_s1_q   <= spi_cs_i;
            cs_s2_q   <= cs_s1_q;
            strobe_q  <= 1'b0;

            if (cs_s2_q || !enable_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                load_q  <= 1'b0;
                miso_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_CMD;
                        cnt_q   <= '0;
                    end
                    S_CMD: begin
                        if (rise) begin
                            cmd_q <= cmd_d[6:0];
                            if (cnt_q == 6'd7) begin
                                rd_q    <= cmd_d[7];
                                addr_q  <= cmd_d[6:0];
                                cnt_q   <= '0;
                                load_q  <= 1'b1;
                                state_q <= S_DATA;
                            end else begin
                                cnt_q <= cnt_q + 6'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        // First fall of each word loads the word; later falls shift it out.
                        if (fall && rd_q) begin
                            if (load_q) begin
                                miso_q  <= rd_word_d[LEN_REGISTER-1];
                                shift_q <= rd_word_d[LEN_REGISTER-2:0];
                                load_q  <= 1'b0;
                            end else begin
                                miso_q  <= shift_q[LEN_REGISTER-2];
                                shift_q <= shift_q << 1;
                            end
                        end
                        if (rise) begin
                            data_q <= data_d[LEN_REGISTER-2:0];
                            if (last_bit) begin
                                if (!rd_q && in_range) begin
                                    regs_q[addr_q*LEN_REGISTER +: LEN_REGISTER] <= data_d;
                                    strobe_q  <= 1'b1;
                                    wr_addr_q <= addr_q;
                                end
                                addr_q <= addr_d;
                                cnt_q  <= '0;
                                load_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 6'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_miso_o  = miso_q;
    assign regs_o      = regs_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: 8 x 8-bit registers, reset values reg[i] = i.
module tb_spi_regfile;

    localparam logic [63:0] RV = 64'h0706050403020100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        miso;
    logic [63:0] regs;
    logic        strobe;
    logic [6:0]  waddr;

    int checks = 0;
    int failures = 0;
    int strobe_cycles = 0;

    spi_regfile #(
        .NUM_REGISTERS(8),
        .LEN_REGISTER (8),
        .RESET_VALUES (RV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (en),
        .spi_sclk_i (sclk),
        .spi_mosi_i (mosi),
        .spi_cs_i   (cs),
        .spi_miso_o (miso),
        .regs_o     (regs),
        .wr_strobe_o(strobe),
        .wr_addr_o  (waddr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) strobe_cycles <= 0;
        else if (strobe) strobe_cycles <= strobe_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            wait_clk(6);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clk(6);
        end
    endtask

    task automatic cs_begin();
        sclk = 1'b0;
        cs   = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        sclk = 1'b0;
        wait_clk(6);
        cs = 1'b1;
        wait_clk(8);
    endtask

    logic [7:0] rx;

    initial begin
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);

        check("reset_regs", regs, RV);
        check("reset_miso", 64'(miso), 64'd0);
        check("reset_strobe", 64'(strobe), 64'd0);
        check("reset_waddr", 64'(waddr), 64'd0);

        // Single write
        cs_begin();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hA5, 8, rx);
        cs_end();
        check("single_regs", regs, 64'h07060504A5020100);
        check("single_strobes", 64'(strobe_cycles), 64'd1);
        check("single_waddr", 64'(waddr), 64'd3);

        // Burst write wrapping 7 -> 0
        cs_begin();
        spi_bits(8'h06, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_bits(8'h33, 8, rx);
        cs_end();
        check("burst_regs", regs, 64'h22110504A5020133);
        check("burst_strobes", 64'(strobe_cycles), 64'd4);
        check("burst_waddr", 64'(waddr), 64'd0);

        // Readback burst from reg 7 wrapping to reg 0
        cs_begin();
        spi_bits(8'h87, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("read_r7", 64'(rx), 64'h22);
        spi_bits(8'hFF, 8, rx);
        check("read_r0", 64'(rx), 64'h33);
        cs_end();
        check("read_regs", regs, 64'h22110504A5020133);
        check("read_strobes", 64'(strobe_cycles), 64'd4);

        // Single read of a mid register
        cs_begin();
        spi_bits(8'h84, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        check("read_r4", 64'(rx), 64'h04);

        // Out-of-range write and read
        cs_begin();
        spi_bits(8'h7F, 8, rx);
        spi_bits(8'hFF, 8, rx);
        cs_end();
        check("oor_regs", regs, 64'h22110504A5020133);
        check("oor_strobes", 64'(strobe_cycles), 64'd4);
        cs_begin();
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        check("oor_read", 64'(rx), 64'h00);

        // Abort after 5 data bits, then a clean transaction
        cs_begin();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'hFF, 5, rx);
        cs_end();
        check("abort_regs", regs, 64'h22110504A5020133);
        check("abort_strobes", 64'(strobe_cycles), 64'd4);
        cs_begin();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h5A, 8, rx);
        cs_end();
        check("after_abort_regs", regs, 64'h22110504A55A0133);
        check("after_abort_waddr", 64'(waddr), 64'd2);
        check("after_abort_strobes", 64'(strobe_cycles), 64'd5);

        // Disabled receiver ignores a full write
        en = 1'b0;
        cs_begin();
        spi_bits(8'h01, 8, rx);
        spi_bits(8'hC3, 8, rx);
        cs_end();
        check("disabled_regs", regs, 64'h22110504A55A0133);
        check("disabled_strobes", 64'(strobe_cycles), 64'd5);
        en = 1'b1;

        // Reset restores all registers
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        check("rereset_regs", regs, RV);
        check("rereset_waddr", 64'(waddr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI-slave register file, the successor to the fixed seven-register SPI receiver. It is generic in register count, register width and reset values, and supports register readback on MISO and auto-incrementing burst access. A single system clock drives it, and it samples the asynchronous SPI pins through synchronisers. It sits between the external SPI host and the design's configuration consumers (colour, sprite and misc control).

## Interface

- NUM_REGISTERS, 8, number of registers, 1..128.
- LEN_REGISTER, 8, bits per register, 2..32.
- RESET_VALUES, 0, packed NUM_REGISTERS*LEN_REGISTER vector; register i occupies bits [i*LEN_REGISTER +: LEN_REGISTER].

Ports:

- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  receiver enable; low forces the FSM idle.
- spi_sclk_i  in  1  SPI clock, asynchronous, mode 0.
- spi_mosi_i  in  1  SPI data in, MSB first.
- spi_cs_i  in  1  chip select, active-low, asynchronous.
- spi_miso_o  out  1  SPI data out.
- regs_o  out  NUM_REGISTERS*LEN_REGISTER  all register contents, same packing as RESET_VALUES.
- wr_strobe_o  out  1  one-cycle pulse when a register is written.
- wr_addr_o  out  7  address of the last written register.

## Operation

- **Input synchronisers:** spi_sclk_i, spi_mosi_i and spi_cs_i pass through 2-flop synchronisers. A third sclk flop provides edge detection: rise = s2 & ~s3, fall = ~s2 & s3.
- **States:**
  - IDLE: CS high or enable_i low.
  - CMD: receiving the 8-bit command.
  - DATA: receiving or sending LEN_REGISTER-bit words.
- **IDLE → CMD:** synchronised CS low and enable_i high. Bit counter = 0.
- **Any state → IDLE:** CS high or enable_i low, checked every cycle with priority over edges. A partial command or word is discarded, no write occurs, and spi_miso_o = 0. Register contents are untouched.
- **CMD:**
  - MOSI is sampled on each sclk rise and shifted in MSB first.
  - On the 8th rise: bit7 = R/W (1 = read), bits[6:0] = address. Address is latched, counter cleared, state → DATA.
- **DATA, write:**
  - LEN_REGISTER rises shift into the data register.
  - On the last rise, if addr < NUM_REGISTERS: write the register, pulse wr_strobe_o, wr_addr_o = addr.
  - Then addr increments, wrapping NUM_REGISTERS-1 → 0, and the FSM stays in DATA for the next word (burst).
- **DATA, read:**
  - At the sclk fall following the 8th command bit, the shift-out register loads reg[addr], or 0 if addr ≥ NUM_REGISTERS, and spi_miso_o = its MSB.
  - Each subsequent fall shifts left by one.
  - On the last rise of a word, addr increments with the same wrap rule. The next fall loads the next register.
  - MOSI is ignored during reads.
- **Out-of-range address:** write data is dropped with no strobe; reads return all zeros. The auto-increment wrap rule still applies to such an address, so bursts wrap to register 0.
- **Reset:** registers = RESET_VALUES, state IDLE, counters 0, spi_miso_o = 0, wr_strobe_o = 0, wr_addr_o = 0, synchroniser flops = 0.
- **Reset vs. write:** rst_i asserted in the same cycle as a write completing → reset wins and the write is lost.

## Timing

- Let N be the clk_i edge at which spi_sclk_i is first sampled high. The detected rise acts at edge N+2: the register update, regs_o change and wr_strobe_o (high for exactly one cycle, N+2..N+3) all occur at edge N+2.
- spi_miso_o changes at edge N+2 relative to the falling sclk, defined the same way.
- SCLK high and low phases must each be ≥ 4 clk_i cycles. CS setup to the first sclk rise must be ≥ 3 clk_i cycles.
- MOSI must be stable ≥ 3 clk_i cycles around each sclk rise; it is sampled from the synchronised copy, aligned with the sclk sync path.
- regs_o is fully registered; no combinational path runs from the SPI pins to regs_o.

## Test plan

- **Reset:** RESET_VALUES = {0x07,…,0x00} (NUM_REGISTERS = 8), pulse rst_i → regs_o equals RESET_VALUES, spi_miso_o = 0, wr_strobe_o = 0.
- **Single write:** cmd 0x03, data 0xA5 → register 3 = 0xA5, one wr_strobe_o pulse with wr_addr_o = 3, all others unchanged.
- **Burst write:** cmd 0x06, data 0x11, 0x22, 0x33 → reg6 = 0x11, reg7 = 0x22, reg0 = 0x33 (wrap), three strobes.
- **Readback burst:** cmd 0x87 after the previous test → MISO yields 0x22 then 0x33 MSB first, registers unchanged.
- **Out of range:** cmd 0x7F, data 0xFF → no strobe, no change; cmd 0xFF → MISO reads 0x00.
- **Abort and disable:**
  - CS raised after 5 data bits of a write to reg 2 → reg 2 unchanged; the next transaction starts cleanly in CMD.
  - enable_i low during a full write → no change.
